spi_ip_shift_engine: RTL and testbench
======================================

Name: spi_ip_shift_engine

Overview:
- SPI master transfer engine; sits directly downstream of the SPI clock divider.
- Enables the divider and consumes its half-period time-base pulse to generate SCK in all four CPOL/CPHA modes.
- Shifts one PARAM_DATA_WIDTH-bit word out on MOSI and captures one word from MISO.
- Uses a start/busy/done handshake towards the register/FIFO layer.

Parameters:
- PARAM_DATA_WIDTH, 8, bits per transfer; legal range 4..32.

Ports:
- shft_clk_i  input  1  system clock.
- shft_rst_i  input  1  synchronous reset, active-high.
- shft_start_i  input  1  transfer request; accepted only in IDLE.
- shft_tx_data_i  input  PARAM_DATA_WIDTH  word to transmit; latched on start acceptance.
- shft_cpol_i  input  1  SCK idle level; latched on start acceptance.
- shft_cpha_i  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on start acceptance.
- shft_time_base_i  input  1  half-SCK-period strobe from the divider.
- shft_miso_i  input  1  serial data in.
- shft_clkd_enable_o  output  1  divider enable; high only in XFER.
- shft_sck_o  output  1  SPI clock (registered).
- shft_mosi_o  output  1  serial data out (registered).
- shft_ss_n_o  output  1  slave select, active-low.
- shft_busy_o  output  1  high in XFER and DONE.
- shft_done_o  output  1  single-cycle completion pulse.
- shft_rx_data_o  output  PARAM_DATA_WIDTH  last received word; held until the next DONE.

Behaviour:
- Synchronous reset: sck=0, mosi=0, ss_n=1, busy=0, done=0, clkd_enable=0, rx_data=0, internal edge counter=0, FSM=IDLE.
- Reset mid-transfer aborts immediately; rx_data is cleared, no done pulse.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - sck <= shft_cpol_i each cycle; time_base ignored.
  - On start=1: latch tx/cpol/cpha, load shift register, edge counter <= 0, ss_n <= 0, busy <= 1, clkd_enable <= 1.
  - mosi <= first bit (MSB) in the same edge, for both CPHA values. Go to XFER.
- XFER: each time_base=1 cycle is one SCK edge. sck <= ~sck, counter++. Edge e = counter+1, range 1..2W.
  - Odd e = leading edge, even e = trailing edge.
  - CPHA=0: sample MISO into shift register on leading edges; drive next bit on trailing edges 2..2W-2; no shift on edge 2W.
  - CPHA=1: drive bit on leading edges (edge 1 re-drives bit W-1, i.e. the MSB, already present); sample on trailing edges.
  - After edge 2W (counter = 2W-1 at tick): sck is back at latched CPOL; go to DONE; clkd_enable <= 0.
  - Cycles with time_base=0 hold all state.
- DONE, exactly one cycle:
  - done=1, rx_data <= received word, ss_n <= 1, busy <= 0 on exit. Next state IDLE.
  - A start asserted in DONE is ignored; it must be re-asserted in IDLE.
- start while busy: ignored, no queuing.
- Edge counter width = clogb2(2*PARAM_DATA_WIDTH); no wrap inside a transfer; reset to 0 on every acceptance.
- Latency: start accepted → done pulse = 2W time_base ticks + 1 clk after the last tick.
- Received bit order: first sampled bit lands in rx_data MSB.

Optional Feature:
- Macro: SPI_IP_LSB_FIRST_EN.
- Defined:
  - Adds input shft_lsb_first_i (1 bit), latched on start acceptance.
  - When 1, tx bit 0 is sent first and the first sampled bit lands in rx_data bit 0.
  - When 0, MSB-first as above.
- Undefined: port absent; MSB-first only.

Test Plan:
- Reset during XFER after edge 5 → next cycle ss_n=1, sck=0, busy=0, rx_data=0, no done pulse.
- W=8, CPOL=0, CPHA=0, tx=0xA5, MISO looped to MOSI, time_base every 4 clks → 16 SCK edges, MOSI bits 1,0,1,0,0,1,0,1 stable at each rising edge, done one clk after the 16th tick, rx_data=0xA5, sck ends at 0.
- CPOL=1, CPHA=1, tx=0x3C, MISO driven 0xC3 by a slave model → sampled on rising (trailing) edges, rx_data=0xC3, sck idles 1 before and after the transfer.
- start pulsed on cycles 2 and 10 of a transfer, and during DONE → ignored; exactly one done pulse; tx latched from the first start only.
- time_base held low 50 clks mid-transfer → sck/mosi/counter frozen, ss_n stays 0; the transfer completes normally once ticks resume.
- With SPI_IP_LSB_FIRST_EN, lsb_first=1, tx=0x01, loopback → first MOSI bit=1, remaining seven bits=0, rx_data=0x01.

Source files
------------

// File: rtl/spi_ip_shift_engine.sv
// spi_ip_shift_engine
// SPI master shift engine. Runs the clock divider only while a transfer is in
// flight and turns each half-period time-base strobe into one SCK edge.
// Supports all four CPOL/CPHA modes with a start/busy/done handshake.
// Optional build macro: SPI_IP_LSB_FIRST_EN adds shft_lsb_first_i, which
// selects LSB-first shifting per transfer. When it is undefined, every
// transfer is MSB-first.
module spi_ip_shift_engine #(
    parameter int PARAM_DATA_WIDTH = 8
) (
    input  logic                        shft_clk_i,
    input  logic                        shft_rst_i,
    input  logic                        shft_start_i,
    input  logic [PARAM_DATA_WIDTH-1:0] shft_tx_data_i,
    input  logic                        shft_cpol_i,
    input  logic                        shft_cpha_i,
`ifdef SPI_IP_LSB_FIRST_EN
    input  logic                        shft_lsb_first_i,
`endif
    input  logic                        shft_time_base_i,
    input  logic                        shft_miso_i,
    output logic                        shft_clkd_enable_o,
    output logic                        shft_sck_o,
    output logic                        shft_mosi_o,
    output logic                        shft_ss_n_o,
    output logic                        shft_busy_o,
    output logic                        shft_done_o,
    output logic [PARAM_DATA_WIDTH-1:0] shft_rx_data_o
);

    localparam int W     = PARAM_DATA_WIDTH;
    localparam int CNT_W = $clog2(2 * W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     tx_q, tx_d, tx_shift;
    logic [W-1:0]     rx_q, rx_d;
    logic [W-1:0]     rx_data_q;
    logic             cpol_q, cpha_q, lsb_q;
    logic             sck_q, mosi_q, mosi_d;
    logic             ss_n_q, busy_q, done_q, clkd_en_q;
    logic             leading, last_edge, do_sample, do_drive;
    logic             lsb_first_w;
    logic             first_bit;

`ifdef SPI_IP_LSB_FIRST_EN
    assign lsb_first_w = shft_lsb_first_i;
`else
    assign lsb_first_w = 1'b0;
`endif

    // The first bit goes on MOSI when the start is accepted, so it is valid
    // before the first SCK edge in both CPHA modes.
    assign first_bit = lsb_first_w ? shft_tx_data_i[0] : shft_tx_data_i[W-1];

    // Edge decode for the current tick. The edge number is cnt_q+1, so an even
    // cnt_q is an odd (leading) edge. The shift-out and shift-in values are
    // prepared here and applied only on a tick.
    always_comb begin
        leading   = ~cnt_q[0];
        last_edge = (cnt_q == CNT_LAST);
        if (cpha_q) begin
            // Edge 1 keeps the bit that was driven when the start was accepted.
            do_drive  = leading && (cnt_q != '0);
            do_sample = ~leading;
        end else begin
            // The final trailing edge would push out a bit that is never sampled.
            do_drive  = ~leading && ~last_edge;
            do_sample = leading;
        end
        tx_shift = lsb_q ? (tx_q >> 1) : (tx_q << 1);
        tx_d     = do_drive ? tx_shift : tx_q;
        mosi_d   = mosi_q;
        if (do_drive)
            mosi_d = lsb_q ? tx_shift[0] : tx_shift[W-1];
        rx_d = rx_q;
        if (do_sample)
            rx_d = lsb_q ? {shft_miso_i, rx_q[W-1:1]} : {rx_q[W-2:0], shft_miso_i};
    end

    // Transfer FSM. Every output is registered here. A reset during a transfer
    // drops it immediately and produces no done pulse.
    always_ff @(posedge shft_clk_i) begin
        if (shft_rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clkd_en_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // SCK follows the requested idle level so that it already
                    // matches CPOL when the transfer starts.
                    sck_q <= shft_cpol_i;
                    if (shft_start_i) begin
                        tx_q      <= shft_tx_data_i;
                        rx_q      <= '0;
                        cpol_q    <= shft_cpol_i;
                        cpha_q    <= shft_cpha_i;
                        lsb_q     <= lsb_first_w;
                        cnt_q     <= '0;
                        mosi_q    <= first_bit;
                        ss_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        clkd_en_q <= 1'b1;
                        state_q   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (shft_time_base_i) begin
                        sck_q  <= ~sck_q;
                        tx_q   <= tx_d;
                        rx_q   <= rx_d;
                        mosi_q <= mosi_d;
                        if (last_edge) begin
                            // Hold the counter at its last value so it never wraps.
                            // rx_data is loaded so it is valid together with done.
                            rx_data_q <= rx_d;
                            done_q    <= 1'b1;
                            clkd_en_q <= 1'b0;
                            state_q   <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    ss_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign shft_clkd_enable_o = clkd_en_q;
    assign shft_sck_o         = sck_q;
    assign shft_mosi_o        = mosi_q;
    assign shft_ss_n_o        = ss_n_q;
    assign shft_busy_o        = busy_q;
    assign shft_done_o        = done_q;
    assign shft_rx_data_o     = rx_data_q;

endmodule

// File: tb/tb_spi_ip_shift_engine.sv
// Directed bench for spi_ip_shift_engine (W=8). A local divider model drives
// the time base. A bus monitor records MOSI at rising SCK edges and acts as a
// simple slave, shifting MISO on trailing edges.
module tb_spi_ip_shift_engine;

    logic       clk;
    logic       rst, start, cpol, cpha, time_base, miso;
    logic [7:0] tx;
    logic       en_o, sck_o, mosi_o, ss_n_o, busy_o, done_o;
    logic [7:0] rx_o;
`ifdef SPI_IP_LSB_FIRST_EN
    logic       lsb_first;
`endif

    int         checks, errors;

    // Divider model controls, written only by the driver.
    int         tb_div;
    bit         tb_freeze;
    bit         loopback;
    logic [7:0] slave_word;

    // Monitor state, written only by the monitors.
    int         cyc, ticks, last_tick, done_cnt, done_cyc, ss_err, sck_rise;
    logic [7:0] slave_sr, mosi_cap;

    spi_ip_shift_engine #(.PARAM_DATA_WIDTH(8)) dut (
        .shft_clk_i        (clk),
        .shft_rst_i        (rst),
        .shft_start_i      (start),
        .shft_tx_data_i    (tx),
        .shft_cpol_i       (cpol),
        .shft_cpha_i       (cpha),
`ifdef SPI_IP_LSB_FIRST_EN
        .shft_lsb_first_i  (lsb_first),
`endif
        .shft_time_base_i  (time_base),
        .shft_miso_i       (miso),
        .shft_clkd_enable_o(en_o),
        .shft_sck_o        (sck_o),
        .shft_mosi_o       (mosi_o),
        .shft_ss_n_o       (ss_n_o),
        .shft_busy_o       (busy_o),
        .shft_done_o       (done_o),
        .shft_rx_data_o    (rx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign miso = loopback ? mosi_o : slave_sr[7];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Divider model: a one-cycle strobe every tb_div clocks while it is enabled.
    initial begin
        int dcnt;
        dcnt = 0;
        time_base = 1'b0;
        forever begin
            @(negedge clk);
            if (en_o === 1'b1 && !tb_freeze) begin
                if (dcnt >= tb_div - 1) begin
                    time_base = 1'b1;
                    dcnt = 0;
                end else begin
                    time_base = 1'b0;
                    dcnt++;
                end
            end else begin
                time_base = 1'b0;
                dcnt = 0;
            end
        end
    end

    // Cycle monitor. last_tick is the index of the cycle in which time_base
    // was high. done_cyc is the cycle in which done is seen.
    initial begin
        logic tick_now;
        cyc = 0; ticks = 0; last_tick = -1; done_cnt = 0; done_cyc = -1; ss_err = 0;
        forever begin
            @(posedge clk);
            tick_now = time_base;
            cyc++;
            if (tick_now) begin
                ticks++;
                last_tick = cyc - 1;
            end
            #2;
            if (done_o === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy_o === ss_n_o) ss_err++;
        end
    end

    // Bus monitor and slave model.
    initial begin
        logic p_sck, p_ss;
        p_sck = 1'b0; p_ss = 1'b1; slave_sr = '0; mosi_cap = '0; sck_rise = 0;
        forever begin
            @(sck_o or ss_n_o or slave_word);
            if (ss_n_o !== 1'b0) slave_sr = slave_word;
            if (p_ss === 1'b1 && ss_n_o === 1'b0) begin
                mosi_cap = '0;
                sck_rise = 0;
            end else if (ss_n_o === 1'b0 && sck_o !== p_sck) begin
                if (sck_o === 1'b1) begin
                    mosi_cap = {mosi_cap[6:0], mosi_o};
                    sck_rise++;
                end
                if (sck_o === cpol) slave_sr = {slave_sr[6:0], 1'b0};
            end
            p_sck = sck_o;
            p_ss  = ss_n_o;
        end
    end

    // Call at a negedge. Returns at the negedge after the start is accepted.
    task automatic do_start(input logic [7:0] d, input logic pol, input logic pha,
                            input logic first);
        cpol = pol;
        cpha = pha;
        repeat (2) @(negedge clk);
        chk("idle_sck", sck_o, pol);
        chk("idle_busy", busy_o, 1'b0);
        tx = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tx = ~d;
        chk("accept_busy_ssn_en", {busy_o, ss_n_o, en_o}, 3'b101);
        chk("accept_mosi", mosi_o, first);
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (done_o !== 1'b1 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk(tag, done_o, 1'b1);
    endtask

    initial begin
        int t0, d0;
        logic s_sck, s_mosi;
        rst = 1'b1; start = 1'b0; tx = '0; cpol = 1'b0; cpha = 1'b0;
        loopback = 1'b1; slave_word = '0; tb_div = 4; tb_freeze = 1'b0;
        checks = 0; errors = 0;
`ifdef SPI_IP_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_outputs", {sck_o, mosi_o, ss_n_o, busy_o, done_o, en_o}, 6'b001000);
        chk("rst_rx", rx_o, 8'h00);
        rst = 1'b0;

        // Mode 0, loopback, 0xA5, tick every 4 clocks.
        t0 = ticks; d0 = done_cnt;
        do_start(8'hA5, 1'b0, 1'b0, 1'b1);
        wait_done("m0_done");
        chk("m0_rx", rx_o, 8'hA5);
        chk("m0_ticks", ticks - t0, 16);
        chk("m0_done_lat", done_cyc - last_tick, 1);
        chk("m0_mosi_bits", mosi_cap, 8'hA5);
        chk("m0_rises", sck_rise, 8);
        chk("m0_sck_end", sck_o, 1'b0);
        chk("m0_en_off", en_o, 1'b0);
        chk("m0_busy_in_done", {busy_o, ss_n_o}, 2'b10);
        @(negedge clk);
        chk("m0_after_done", {done_o, busy_o, ss_n_o}, 3'b001);
        repeat (5) @(negedge clk);
        chk("m0_done_pulses", done_cnt - d0, 1);

        // Mode 3, slave returns 0xC3 while the master sends 0x3C.
        loopback = 1'b0; slave_word = 8'hC3;
        do_start(8'h3C, 1'b1, 1'b1, 1'b0);
        wait_done("m3_done");
        chk("m3_rx", rx_o, 8'hC3);
        chk("m3_mosi_bits", mosi_cap, 8'h3C);
        chk("m3_sck_end", sck_o, 1'b1);
        repeat (3) @(negedge clk);
        chk("m3_sck_idle", {sck_o, ss_n_o}, 2'b11);

        // A start seen while busy or in DONE is ignored.
        loopback = 1'b1;
        d0 = done_cnt;
        do_start(8'h5A, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; tx = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        start = 1'b1; tx = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_done");
        chk("ign_rx", rx_o, 8'h5A);
        start = 1'b1; tx = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("ign_idle", {busy_o, ss_n_o, en_o}, 3'b010);
        chk("ign_done_pulses", done_cnt - d0, 1);

        // The time base stalls for 50 clocks in the middle of a transfer.
        tb_div = 2;
        t0 = ticks;
        do_start(8'h96, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 500 && (ticks - t0) < 5; i++) @(negedge clk);
        tb_freeze = 1'b1;
        repeat (2) @(negedge clk);
        s_sck = sck_o; s_mosi = mosi_o; t0 = ticks - t0; d0 = ticks;
        repeat (50) @(negedge clk);
        chk("frz_hold", {sck_o, mosi_o}, {s_sck, s_mosi});
        chk("frz_ssn_busy", {ss_n_o, busy_o, done_o}, 3'b010);
        chk("frz_no_ticks", ticks - d0, 0);
        tb_freeze = 1'b0;
        d0 = ticks - t0;
        wait_done("frz_done");
        chk("frz_rx", rx_o, 8'h96);
        chk("frz_ticks", ticks - d0, 16);
        chk("frz_ss_consistent", ss_err, 0);

        // Reset after edge 5 aborts the transfer and produces no done pulse.
        tb_div = 4;
        t0 = ticks; d0 = done_cnt;
        do_start(8'hFF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 500 && (ticks - t0) < 5; i++) @(negedge clk);
        chk("rst_edge5_reached", ticks - t0, 5);
        chk("rst_pre_sck", sck_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_abort_out", {ss_n_o, sck_o, busy_o, done_o, en_o}, 5'b10000);
        chk("rst_abort_rx", rx_o, 8'h00);
        repeat (40) @(negedge clk);
        chk("rst_no_done", done_cnt - d0, 0);

`ifdef SPI_IP_LSB_FIRST_EN
        // LSB-first loopback of 0x01.
        lsb_first = 1'b1;
        do_start(8'h01, 1'b0, 1'b0, 1'b1);
        lsb_first = 1'b0;
        wait_done("lsb_done");
        chk("lsb_mosi_order", mosi_cap, 8'h80);
        chk("lsb_rx", rx_o, 8'h01);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
